// File: rtl/mem_dist_arb.sv
// mem_dist / mem_dist_arb
//
// mem_dist: simple dual-port distributed RAM.
//   Port A is write-only: enA, weA, addrA, dinA, all on clkA.
//   Port B is read-only: enB, addrB. doutB is registered on clkB and is
//   synchronously cleared by rstB.
//   The memory array itself is never reset.
//
// mem_dist_arb: shares one mem_dist between NREQ requesters.
//   The write and read ports each have an independent round-robin arbiter.
//   clkA     clock; all logic is on the rising edge
//   rst      synchronous, active-high reset of the control state
//   wr_req   per-requester write request
//   wr_addr  write addresses; requester i uses [i*AW +: AW]
//   wr_data  write data; requester i uses [i*WIDTH +: WIDTH]
//   wr_gnt   one-hot write grant (combinational)
//   rd_req   per-requester read request
//   rd_addr  read addresses, packed like wr_addr
//   rd_gnt   one-hot read grant (combinational)
//   rd_valid read response valid (registered)
//   rd_id    index of the requester that owns the response
//   rd_data  read response data (the RAM's registered doutB)

module mem_dist #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clkA,
    input  logic             clkB,
    input  logic             enA,
    input  logic             weA,
    input  logic [AW-1:0]    addrA,
    input  logic [WIDTH-1:0] dinA,
    input  logic             enB,
    input  logic             rstB,
    input  logic [AW-1:0]    addrB,
    output logic [WIDTH-1:0] doutB
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clkA) begin
        if (enA && weA)
            mem[addrA] <= dinA;
    end

    // A same-edge read of the address being written sees the old word.
    always_ff @(posedge clkB) begin
        if (rstB)
            doutB <= '0;
        else if (enB)
            doutB <= mem[addrB];
    end

endmodule

module mem_dist_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic                 clkA,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wr_req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]      wr_gnt,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ-1:0]      rd_gnt,
    output logic                 rd_valid,
    output logic [IW-1:0]        rd_id,
    output logic [WIDTH-1:0]     rd_data
);

    logic [IW-1:0]    wptr, rptr;
    logic [IW-1:0]    widx, ridx;
    logic [AW-1:0]    addrA, addrB;
    logic [WIDTH-1:0] dinA;
    logic             wr_any, rd_any;

    // First asserted request at or after ptr, scanning upward modulo NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IW-1:0]   ptr);
        logic [NREQ-1:0] g;
        logic [IW-1:0]   idx;
        g = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr) + k) % NREQ);
            if (g == '0 && req[idx])
                g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [IW-1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh[i])
                idx = idx | IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] g);
        return (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
    endfunction

    always_comb begin
        wr_gnt = rst ? '0 : rr_pick(wr_req, wptr);
        rd_gnt = rst ? '0 : rr_pick(rd_req, rptr);
        wr_any = |wr_gnt;
        rd_any = |rd_gnt;
        widx   = oh2idx(wr_gnt);
        ridx   = oh2idx(rd_gnt);
    end

    always_comb begin
        addrA = '0;
        dinA  = '0;
        addrB = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (wr_gnt[i]) begin
                addrA = wr_addr[i*AW +: AW];
                dinA  = wr_data[i*WIDTH +: WIDTH];
            end
            if (rd_gnt[i])
                addrB = rd_addr[i*AW +: AW];
        end
    end

    always_ff @(posedge clkA) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            if (wr_any)
                wptr <= ptr_next(widx);
            if (rd_any) begin
                rptr  <= ptr_next(ridx);
                rd_id <= ridx;
            end
            rd_valid <= rd_any;
        end
    end

    mem_dist #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clkA  (clkA),
        .clkB  (clkA),
        .enA   (wr_any),
        .weA   (wr_any),
        .addrA (addrA),
        .dinA  (dinA),
        .enB   (rd_any),
        .rstB  (rst),
        .addrB (addrB),
        .doutB (rd_data)
    );

endmodule

// File: tb/tb_mem_dist_arb.sv
// Testbench for mem_dist_arb (WIDTH=32, DEPTH=512, NREQ=4).
// Each vector is one clock cycle: drive, check grants, then check the
// registered response after the edge against a scoreboard queue.

module tb_mem_dist_arb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int NREQ  = 4;
    localparam int AW    = 9;
    localparam int IW    = 2;

    logic                  clkA = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       wr_req, rd_req, wr_gnt, rd_gnt;
    logic [NREQ*AW-1:0]    wr_addr, rd_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [IW-1:0]         rd_id;
    logic [WIDTH-1:0]      rd_data;

    always #5 clkA = ~clkA;

    mem_dist_arb #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NREQ  (NREQ)
    ) dut (
        .clkA     (clkA),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data)
    );

    typedef struct {
        logic             rs;
        logic [NREQ-1:0]  wq, rq, ewg, erg;
        logic [AW-1:0]    wa, ra;
        logic [WIDTH-1:0] wd;
    } vec_t;

    typedef struct {
        logic [IW-1:0]    id;
        logic [WIDTH-1:0] data;
        bit               known;
    } exp_t;

    vec_t             tbl1[$], tbl2[$];
    exp_t             sb[$];
    logic [WIDTH-1:0] model [DEPTH];
    bit               known [DEPTH];
    logic [IW-1:0]    hold_id;
    logic [WIDTH-1:0] hold_data;
    bit               hold_known;
    int               checks = 0;
    int               errors = 0;
    int               row = 0;

    function automatic vec_t mk(input logic rs, input logic [NREQ-1:0] wq,
                                input logic [NREQ-1:0] rq, input logic [AW-1:0] wa,
                                input logic [WIDTH-1:0] wd, input logic [AW-1:0] ra,
                                input logic [NREQ-1:0] ewg, input logic [NREQ-1:0] erg);
        vec_t v;
        v.rs = rs; v.wq = wq; v.rq = rq; v.wa = wa; v.wd = wd;
        v.ra = ra; v.ewg = ewg; v.erg = erg;
        return v;
    endfunction

    function automatic int first_bit(input logic [NREQ-1:0] oh);
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) return i;
        return NREQ;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d %s: got 0x%0h expected 0x%0h", row, name, act, exp);
        end
    endtask

    // Non-target requesters carry decoy addresses/data so a wrong slice
    // selection shows up as wrong data.
    task automatic run(input vec_t v);
        int   wt, rt;
        bit   ev;
        exp_t e;
        wt = first_bit(v.ewg);
        rt = first_bit(v.erg);
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*AW +: AW]       = (i == wt) ? v.wa : v.wa + AW'((i + 1) * 64);
            wr_data[i*WIDTH +: WIDTH] = (i == wt) ? v.wd : ~v.wd ^ WIDTH'(i);
            rd_addr[i*AW +: AW]       = (i == rt) ? v.ra : v.ra + AW'((i + 1) * 64);
        end
        if (32'(v.wa) >= DEPTH || 32'(v.ra) >= DEPTH) begin
            errors++;
            $display("FAIL row%0d illegal address", row);
        end
        rst    = v.rs;
        wr_req = v.wq;
        rd_req = v.rq;
        #1;
        chk("wr_gnt", 64'(wr_gnt), 64'(v.ewg));
        chk("rd_gnt", 64'(rd_gnt), 64'(v.erg));
        ev = (v.erg != '0) && !v.rs;
        if (ev) begin
            e.id    = IW'(rt);
            e.data  = model[v.ra];
            e.known = known[v.ra];
            sb.push_back(e);
        end
        if (v.ewg != '0 && !v.rs) begin
            model[v.wa] = v.wd;
            known[v.wa] = 1'b1;
        end
        @(posedge clkA);
        #1;
        if (v.rs) begin
            hold_id    = '0;
            hold_data  = '0;
            hold_known = 1'b1;
        end
        chk("rd_valid", 64'(rd_valid), 64'(ev));
        if (ev) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL row%0d scoreboard underflow", row);
            end else begin
                e = sb.pop_front();
                chk("rd_id", 64'(rd_id), 64'(e.id));
                if (e.known)
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                hold_id    = e.id;
                hold_data  = e.data;
                hold_known = e.known;
            end
        end else begin
            chk("rd_id_hold", 64'(rd_id), 64'(hold_id));
            if (hold_known)
                chk("rd_data_hold", 64'(rd_data), 64'(hold_data));
        end
        row++;
    endtask

    initial begin
        logic [AW-1:0] rr_ra [8];
        logic [AW-1:0] sp_ra [4];
        rr_ra = '{9'h005, 9'h040, 9'h041, 9'h030, 9'h042, 9'h043, 9'h044, 9'h045};
        sp_ra = '{9'h005, 9'h009, 9'h010, 9'h040};

        // Reset with everyone requesting, then both ports start at requester 0.
        for (int k = 0; k < 3; k++)
            tbl1.push_back(mk(1'b1, 4'hF, 4'hF, 9'h010, 32'h0, 9'h010, 4'h0, 4'h0));
        tbl1.push_back(mk(1'b0, 4'hF, 4'hF, 9'h010, 32'hA0A0_0000, 9'h011, 4'h1, 4'h1));
        // Requester 2 writes, requester 1 reads it back next cycle.
        tbl1.push_back(mk(1'b0, 4'b0100, 4'h0, 9'h005, 32'hDEAD_BEEF, 9'h000, 4'b0100, 4'h0));
        tbl1.push_back(mk(1'b0, 4'h0, 4'b0010, 9'h000, 32'h0, 9'h005, 4'h0, 4'b0010));
        tbl1.push_back(mk(1'b0, 4'h0, 4'h0, 9'h000, 32'h0, 9'h000, 4'h0, 4'h0));

        // Bring both pointers to 0, then round-robin on both ports.
        tbl2.push_back(mk(1'b0, 4'b1000, 4'b1000, 9'h030, 32'h3333_0000, 9'h010, 4'b1000, 4'b1000));
        for (int k = 0; k < 8; k++)
            tbl2.push_back(mk(1'b0, 4'hF, 4'hF, AW'(9'h040 + k), 32'hC0DE_0000 + 32'(k),
                              rr_ra[k], 4'(1 << (k % 4)), 4'(1 << (k % 4))));
        // Sparse readers 1 and 3 alternate.
        for (int k = 0; k < 4; k++)
            tbl2.push_back(mk(1'b0, 4'h0, 4'b1010, 9'h000, 32'h0, sp_ra[k], 4'h0,
                              (k % 2 == 0) ? 4'b0010 : 4'b1000));

        for (int a = 0; a < DEPTH; a++) begin
            known[a] = 1'b0;
            model[a] = '0;
        end
        hold_id = '0; hold_data = '0; hold_known = 1'b0;
        rst = 1'b1; wr_req = '0; rd_req = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        @(posedge clkA);
        #1;

        foreach (tbl1[i]) run(tbl1[i]);

        // Same-address collision: read sees old word, next read sees new one.
        run(mk(1'b0, 4'b0001, 4'h0, 9'h009, 32'h0000_0011, 9'h000, 4'b0001, 4'h0));
        run(mk(1'b0, 4'b0001, 4'b1000, 9'h009, 32'h0000_0022, 9'h009, 4'b0001, 4'b1000));
        run(mk(1'b0, 4'h0, 4'b0001, 9'h000, 32'h0, 9'h009, 4'h0, 4'b0001));

        foreach (tbl2[i]) run(tbl2[i]);

        // Reset mid-stream once both pointers reach 2; RAM must survive.
        run(mk(1'b0, 4'hF, 4'hF, 9'h050, 32'h5050_0000, 9'h010, 4'b0001, 4'b0001));
        run(mk(1'b0, 4'hF, 4'hF, 9'h051, 32'h5151_0000, 9'h005, 4'b0010, 4'b0010));
        run(mk(1'b1, 4'hF, 4'hF, 9'h009, 32'hBAD0_0000, 9'h009, 4'h0, 4'h0));
        run(mk(1'b0, 4'hF, 4'hF, 9'h052, 32'h5252_0000, 9'h009, 4'b0001, 4'b0001));
        run(mk(1'b0, 4'h0, 4'b0010, 9'h000, 32'h0, 9'h050, 4'h0, 4'b0010));
        run(mk(1'b0, 4'h0, 4'h0, 9'h000, 32'h0, 9'h000, 4'h0, 4'h0));

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
